// File: rtl/dff_pipe_arbiter.sv
// dff_pipe_arbiter: round-robin arbiter feeding a shared DEPTH-stage register
// pipeline. One requester is granted per cycle; its data, a valid bit and its
// source ID travel down the pipeline together. A requester holding lock may
// keep the grant for up to MAX_BURST consecutive cycles. hold stalls all state.
module dff_pipe_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*WIDTH-1:0]     din,
  input  logic                      hold,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          y,
  output logic                      y_vld,
  output logic [$clog2(NREQ)-1:0]   y_src,
  output logic                      busy
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            scan_found;
  logic [SW-1:0]   scan_win;
  logic            burst_cont;
  logic            take;
  logic [SW-1:0]   win;

  logic [WIDTH-1:0] dat_p [DEPTH];
  logic             vld_p [DEPTH];
  logic [SW-1:0]    src_p [DEPTH];

  // Round-robin search: first active request at or after ptr, wrapping.
  always_comb begin
    scan_found = 1'b0;
    scan_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!scan_found && req[ptr_q + SW'(k)]) begin
        scan_found = 1'b1;
        scan_win   = ptr_q + SW'(k);
      end
    end
  end

  // Grant selection and next arbiter/burst state; a finished burst falls
  // straight into normal arbitration in the same cycle, so no bubble.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    gnt        = '0;
    take       = 1'b0;
    win        = '0;
    burst_cont = (state_q == BURST) && req[owner_q] && lock[owner_q] &&
                 (cnt_q < CW'(MAX_BURST));
    if (rst && !hold) begin
      if (burst_cont) begin
        take  = 1'b1;
        win   = owner_q;
        cnt_d = cnt_q + CW'(1);
      end else if (scan_found) begin
        take  = 1'b1;
        win   = scan_win;
        ptr_d = scan_win + SW'(1);
        if (lock[scan_win]) begin
          state_d = BURST;
          owner_d = scan_win;
          cnt_d   = CW'(1);
        end else begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end else begin
        state_d = ARB;
        cnt_d   = '0;
      end
      if (take) gnt[win] = 1'b1;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register pipeline: stage 0 captures the granted data, later stages shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        dat_p[k] <= '0;
        vld_p[k] <= 1'b0;
        src_p[k] <= '0;
      end
    end else if (!hold) begin
      // stage 1: capture (data and source hold their value on a bubble)
      vld_p[0] <= take;
      if (take) begin
        dat_p[0] <= din[win*WIDTH +: WIDTH];
        src_p[0] <= win;
      end
      // stages 2..DEPTH: shift
      for (int k = 1; k < DEPTH; k++) begin
        dat_p[k] <= dat_p[k-1];
        vld_p[k] <= vld_p[k-1];
        src_p[k] <= src_p[k-1];
      end
    end
  end

  // Output taps and pipeline occupancy.
  always_comb begin
    y     = dat_p[DEPTH-1];
    y_vld = vld_p[DEPTH-1];
    y_src = src_p[DEPTH-1];
    busy  = 1'b0;
    for (int k = 0; k < DEPTH; k++) busy = busy | vld_p[k];
  end

endmodule

// File: tb/tb_dff_pipe_arbiter.sv
// Bench for dff_pipe_arbiter: table of directed vectors, hand-written burst,
// hold and reset sequences, then random traffic against a behavioural model.
module tb_dff_pipe_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 4;
  localparam int DEPTH     = 2;
  localparam int MAX_BURST = 4;
  localparam int SW        = $clog2(NREQ);

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ*WIDTH-1:0]  din;
  logic                   hold;
  logic [NREQ-1:0]        gnt;
  logic [WIDTH-1:0]       y;
  logic                   y_vld;
  logic [SW-1:0]          y_src;
  logic                   busy;

  dff_pipe_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din), .hold(hold),
    .gnt(gnt), .y(y), .y_vld(y_vld), .y_src(y_src), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [WIDTH-1:0] d;
    bit               v;
    int               s;
  } stg_t;

  stg_t pq[$];          // pq[0] = first stage, pq[DEPTH-1] = output stage
  int   m_ptr, m_owner, m_cnt;
  bit   m_burst;

  task automatic model_reset();
    stg_t z;
    z.d = '0; z.v = 1'b0; z.s = 0;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 1'b0;
    pq.delete();
    for (int i = 0; i < DEPTH; i++) pq.push_back(z);
  endtask

  // Winner this cycle (-1 if none); cont says the current burst continues.
  function automatic int m_winner(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                                  output bit cont);
    cont = m_burst && r[m_owner] && l[m_owner] && (m_cnt < MAX_BURST);
    if (cont) return m_owner;
    for (int k = 0; k < NREQ; k++) begin
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_gnt(input logic [NREQ-1:0] r,
                                            input logic [NREQ-1:0] l, input logic h);
    bit c;
    int w;
    logic [NREQ-1:0] g;
    g = '0;
    w = m_winner(r, l, c);
    if (!h && w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                            input logic h, input logic [NREQ*WIDTH-1:0] d);
    bit   c;
    int   w;
    stg_t n;
    if (h) return;
    w = m_winner(r, l, c);
    if (w >= 0) begin
      n.d = d[w*WIDTH +: WIDTH]; n.v = 1'b1; n.s = w;
    end else begin
      n.d = pq[0].d; n.v = 1'b0; n.s = pq[0].s;
    end
    if (c) m_cnt++;
    else if (w >= 0) begin
      m_ptr = (w + 1) % NREQ;
      if (l[w]) begin m_burst = 1'b1; m_owner = w; m_cnt = 1; end
      else      begin m_burst = 1'b0; m_cnt = 0; end
    end else begin
      m_burst = 1'b0; m_cnt = 0;
    end
    pq.push_front(n);
    void'(pq.pop_back());
  endtask

  task automatic model_check(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                             input logic h);
    bit b;
    b = 1'b0;
    foreach (pq[i]) b = b | pq[i].v;
    chk("gnt", gnt, m_gnt(r, l, h));
    chk("y", y, pq[DEPTH-1].d);
    chk("y_vld", y_vld, pq[DEPTH-1].v);
    if (pq[DEPTH-1].v) chk("y_src", y_src, pq[DEPTH-1].s);
    chk("busy", busy, b);
  endtask

  // One clock: drive just after an edge, check at the falling edge, advance.
  task automatic run_cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                           input logic h, input logic [NREQ*WIDTH-1:0] d,
                           output logic [NREQ-1:0] g);
    req = r; lock = l; hold = h; din = d;
    @(negedge clk);
    g = gnt;
    model_check(r, l, h);
    @(posedge clk);
    model_edge(r, l, h, d);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic                  hold;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      y;
    logic                  vld;
    int                    src;
    logic                  busy;
  } vec_t;

  vec_t tv[12];

  logic [NREQ-1:0] g;
  logic [NREQ-1:0] exp4 [10];
  logic [NREQ-1:0] exp5 [4];
  logic [NREQ-1:0] exp6 [7];
  logic            hld6 [7];

  initial begin
    // single requester 1 with data A, then drain
    tv[0]  = '{4'b0010, 4'b0000, 1'b0, 16'h00A0, 4'b0010, 4'h0, 1'b0, -1, 1'b0};
    tv[1]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, -1, 1'b1};
    tv[2]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'hA, 1'b1,  1, 1'b1};
    tv[3]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'hA, 1'b0, -1, 1'b0};
    // all requesting, no lock, round robin from ptr=2
    tv[4]  = '{4'b1111, 4'b0000, 1'b0, 16'h4321, 4'b0100, 4'hA, 1'b0, -1, 1'b0};
    tv[5]  = '{4'b1111, 4'b0000, 1'b0, 16'h4321, 4'b1000, 4'hA, 1'b0, -1, 1'b1};
    tv[6]  = '{4'b1111, 4'b0000, 1'b0, 16'h4321, 4'b0001, 4'h3, 1'b1,  2, 1'b1};
    tv[7]  = '{4'b1111, 4'b0000, 1'b0, 16'h4321, 4'b0010, 4'h4, 1'b1,  3, 1'b1};
    tv[8]  = '{4'b1111, 4'b0000, 1'b0, 16'h4321, 4'b0100, 4'h1, 1'b1,  0, 1'b1};
    tv[9]  = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'h2, 1'b1,  1, 1'b1};
    tv[10] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'h3, 1'b1,  2, 1'b1};
    tv[11] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 4'h3, 1'b0, -1, 1'b0};

    exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
             4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    exp5 = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};
    exp6 = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
    hld6 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset held for two cycles
    rst = 1'b0; req = '0; lock = '0; din = '0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 0);
    chk("rst_vld", y_vld, 0);
    chk("rst_src", y_src, 0);
    chk("rst_busy", busy, 0);
    req = 4'b1111;
    #1;
    chk("rst_gnt", gnt, 0);
    req = '0;
    rst = 1'b1;

    // table vectors
    for (int i = 0; i < 12; i++) begin
      req = tv[i].req; lock = tv[i].lock; hold = tv[i].hold; din = tv[i].din;
      @(negedge clk);
      chk($sformatf("tv%0d_gnt", i), gnt, tv[i].gnt);
      chk($sformatf("tv%0d_y", i), y, tv[i].y);
      chk($sformatf("tv%0d_vld", i), y_vld, tv[i].vld);
      if (tv[i].src >= 0) chk($sformatf("tv%0d_src", i), y_src, tv[i].src);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      @(posedge clk);
      model_edge(tv[i].req, tv[i].lock, tv[i].hold, tv[i].din);
      #1;
    end

    // locked bursts of MAX_BURST from requester 0 alternating with requester 1
    for (int i = 0; i < 10; i++) begin
      run_cycle(4'b0011, 4'b0001, 1'b0, 16'h8421, g);
      chk($sformatf("burst_gnt%0d", i), g, exp4[i]);
    end

    // lock dropped after two grants ends the burst early
    for (int i = 0; i < 4; i++) begin
      run_cycle(4'b0011, (i < 2) ? 4'b0001 : 4'b0000, 1'b0, 16'h8421, g);
      chk($sformatf("unlock_gnt%0d", i), g, exp5[i]);
    end

    // hold for three cycles mid-stream, order resumes at pre-hold pointer
    for (int i = 0; i < 7; i++) begin
      run_cycle(4'b1111, 4'b0000, hld6[i], 16'hDCBA, g);
      chk($sformatf("hold_gnt%0d", i), g, exp6[i]);
    end
    repeat (3) run_cycle(4'b0000, 4'b0000, 1'b0, 16'h0000, g);

    // asynchronous reset between edges while the pipeline is full
    repeat (2) run_cycle(4'b1111, 4'b0000, 1'b0, 16'h5A5A, g);
    #3 rst = 1'b0;
    #1;
    chk("arst_y", y, 0);
    chk("arst_vld", y_vld, 0);
    chk("arst_src", y_src, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gnt", gnt, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_cycle(4'b0110, 4'b0000, 1'b0, 16'h0770, g);
    chk("arst_first_gnt", g, 4'b0010);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      run_cycle(NREQ'($urandom), NREQ'($urandom),
                ($urandom_range(0, 7) == 0), (NREQ*WIDTH)'($urandom), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
